// File: rtl/uart_cmd_host.sv
// Host-side command engine: parses ASCII hex read/write commands from the RX FIFO,
// drives a simple register bus and returns an ASCII response through the TX FIFO.
module uart_cmd_host #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       rx_empty_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_en_o,
    input  logic       tx_full_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        StIdle, StAddrHi, StAddrLo, StDataHi, StDataLo, StEol, StErr, StExec, StResp
    } state_e;

    typedef enum logic [1:0] {RespRead, RespWrite, RespErr} resp_e;

    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChLf = 8'h0A;

    // {valid, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end
        return 5'b0;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_e      state_q, state_d;
    resp_e       resp_q, resp_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] to_cnt_q, to_cnt_d;

    logic       parsing, accepting, pop, push, is_hex, is_cr, is_lf, cmd_r, cmd_w;
    logic       timeout_hit, resp_done;
    logic [3:0] nib;

    assign parsing   = (state_q == StAddrHi) || (state_q == StAddrLo) ||
                       (state_q == StDataHi) || (state_q == StDataLo) || (state_q == StEol);
    assign accepting = parsing || (state_q == StIdle) || (state_q == StErr);
    assign pop       = accepting && !rx_empty_i;
    assign push      = (state_q == StResp) && !tx_full_i;
    assign {is_hex, nib} = hex_decode(rx_data_i);
    assign is_cr     = (rx_data_i == ChCr);
    assign is_lf     = (rx_data_i == ChLf);
    assign cmd_r     = (rx_data_i == 8'h52) || (rx_data_i == 8'h72);
    assign cmd_w     = (rx_data_i == 8'h57) || (rx_data_i == 8'h77);
    assign resp_done = push && (idx_q == ((resp_q == RespRead) ? 2'd3 : 2'd2));

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a partial command.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && parsing && !pop &&
                         (to_cnt_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (cmd_r || cmd_w)       state_d = StAddrHi;
                    else if (!is_cr && !is_lf) state_d = StErr;
                end
            end
            StAddrHi: if (pop) state_d = is_hex ? StAddrLo : StErr;
            StAddrLo: if (pop) state_d = !is_hex ? StErr : (is_write_q ? StDataHi : StEol);
            StDataHi: if (pop) state_d = is_hex ? StDataLo : StErr;
            StDataLo: if (pop) state_d = is_hex ? StEol : StErr;
            StEol:    if (pop) state_d = is_cr ? StExec : StErr;
            StErr:    if (pop && is_cr) state_d = StResp;
            StExec:   state_d = StResp;
            StResp:   if (resp_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout_hit) state_d = StIdle;
    end

    always_comb begin
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        idx_d      = 2'd0;
        to_cnt_d   = (parsing && !pop && !timeout_hit) ? to_cnt_q + 32'd1 : 32'd0;
        if (pop && is_hex) begin
            if (state_q == StAddrHi) addr_d[7:4]  = nib;
            if (state_q == StAddrLo) addr_d[3:0]  = nib;
            if (state_q == StDataHi) wdata_d[7:4] = nib;
            if (state_q == StDataLo) wdata_d[3:0] = nib;
        end
        if (state_q == StIdle && pop && (cmd_r || cmd_w)) is_write_d = cmd_w;
        if (state_q == StErr && pop && is_cr) resp_d = RespErr;
        if (state_q == StExec) begin
            rdata_d = reg_rdata_i;
            resp_d  = is_write_q ? RespWrite : RespRead;
        end
        if (state_q == StResp) idx_d = push ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            resp_q     <= RespErr;
            is_write_q <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            idx_q      <= 2'd0;
            to_cnt_q   <= 32'd0;
        end else begin
            resp_q     <= resp_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        rx_en_o     = pop;
        tx_en_o     = push;
        reg_we_o    = (state_q == StExec) && is_write_q;
        reg_addr_o  = addr_q;
        reg_wdata_o = wdata_q;
        busy_o      = (state_q != StIdle);
        tx_data_o   = 8'h00;
        if (state_q == StResp) begin
            if (resp_q == RespRead) begin
                case (idx_q)
                    2'd0:    tx_data_o = hex_ascii(rdata_q[7:4]);
                    2'd1:    tx_data_o = hex_ascii(rdata_q[3:0]);
                    2'd2:    tx_data_o = ChCr;
                    default: tx_data_o = ChLf;
                endcase
            end else begin
                case (idx_q)
                    2'd0:    tx_data_o = (resp_q == RespWrite) ? 8'h4B : 8'h3F;
                    2'd1:    tx_data_o = ChCr;
                    2'd2:    tx_data_o = ChLf;
                    default: tx_data_o = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host: RX FIFO and register models, string-level command model,
// per-cycle comparison of TX pushes and register writes.
module tb_uart_cmd_host;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       tx_full;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_count = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic [15:0] exp_wr[$];
    logic [15:0] wr_front;
    logic [7:0]  regmem[256];
    logic [7:0]  shadow[256];
    logic        rx_pop_s;
    string       hexdig = "0123456789ABCDEF";

    always #5 clk = ~clk;

    uart_cmd_host #(.TIMEOUT_CYCLES(50)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .rx_empty_i  (rx_empty),
        .rx_data_i   (rx_data),
        .rx_en_o     (rx_en),
        .tx_full_i   (tx_full),
        .tx_en_o     (tx_en),
        .tx_data_o   (tx_data),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_we_o    (reg_we),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead RX FIFO; updated just after the edge so the DUT sees stable data.
    always @(posedge clk) begin
        rx_pop_s = rx_en;
        #1;
        if (rx_pop_s && rx_q.size() != 0) rx_q.delete(0);
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    always @(posedge clk) if (reg_we) regmem[reg_addr] <= reg_wdata;
    always_comb reg_rdata = regmem[reg_addr];

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (tx_en) begin
                check("tx_en_while_full", int'(tx_full), 0);
                if (exp_tx.size() == 0) check("tx_unexpected_push", exp_tx.size(), 1);
                else check("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
                tx_log.push_back(tx_data);
            end
            if (reg_we) begin
                we_count++;
                if (exp_wr.size() == 0) begin
                    check("we_unexpected", exp_wr.size(), 1);
                end else begin
                    wr_front = exp_wr.pop_front();
                    check("we_addr", int'(reg_addr), int'(wr_front[15:8]));
                    check("we_data", int'(reg_wdata), int'(wr_front[7:0]));
                end
            end
            if (!busy) check("tx_data_idle", int'(tx_data), 0);
        end
    end

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] c);
        if (c <= 8'h39) return c[3:0];
        return c[3:0] + 4'd9;
    endfunction

    // Line-level model: every CR-terminated line yields one response. Vectors never end a
    // line early, so a malformed line's first bad byte is never its CR.
    task automatic model(input string s);
        int i, e;
        logic [7:0] c0, a, d, ch;
        bit ok;
        i = 0;
        while (i < s.len()) begin
            ch = s[i];
            if (ch == 8'h0D || ch == 8'h0A) begin
                i++;
                continue;
            end
            e = i;
            while (e < s.len() && s[e] != 8'h0D) e++;
            if (e >= s.len()) break;
            c0 = ch & 8'hDF;
            ok = (c0 == 8'h52 && e - i == 3) || (c0 == 8'h57 && e - i == 5);
            for (int j = i + 1; j < e; j++) if (!is_hex(s[j])) ok = 1'b0;
            if (!ok) begin
                exp_tx.push_back(8'h3F);
            end else begin
                a = {nib(s[i+1]), nib(s[i+2])};
                if (c0 == 8'h57) begin
                    d = {nib(s[i+3]), nib(s[i+4])};
                    shadow[a] = d;
                    exp_wr.push_back({a, d});
                    exp_tx.push_back(8'h4B);
                end else begin
                    d = shadow[a];
                    exp_tx.push_back(hexdig[d[7:4]]);
                    exp_tx.push_back(hexdig[d[3:0]]);
                end
            end
            exp_tx.push_back(8'h0D);
            exp_tx.push_back(8'h0A);
            i = e + 1;
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    task automatic cmd(input string s);
        model(s);
        send(s);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        @(negedge clk);
        while ((rx_q.size() != 0 || busy || exp_tx.size() != 0 || exp_wr.size() != 0)
               && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done_in_time"}, int'(k < 2000), 1);
    endtask

    task automatic check_log(input string name, input string exp);
        check({name, "_len"}, tx_log.size(), exp.len());
        if (tx_log.size() == exp.len())
            for (int i = 0; i < exp.len(); i++) check({name, "_byte"}, int'(tx_log[i]), int'(exp[i]));
        tx_log.delete();
    endtask

    initial begin
        int k, cr_cyc, we0;
        for (int i = 0; i < 256; i++) begin
            regmem[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        regmem[8'h3C] = 8'h7E;
        shadow[8'h3C] = 8'h7E;
        reset_n = 1'b0;
        tx_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_en", int'(rx_en), 0);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_reg_we", int'(reg_we), 0);
        check("rst_reg_addr", int'(reg_addr), 0);
        check("rst_reg_wdata", int'(reg_wdata), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;

        // Lowercase read with trailing LF swallowed in idle.
        cmd("r3c\015\012");
        wait_done("read_3c");
        check_log("read_3c", "7E\015\012");
        check("read_no_we", we_count, 0);

        // Write with CR-to-first-push latency.
        cmd("W3CA5\015");
        k = 0;
        cr_cyc = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rx_en && rx_data == 8'h0D) && k < 100);
        cr_cyc = cyc;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_en && k < 200);
        check("write_latency", cyc - cr_cyc, 2);
        wait_done("write");
        check_log("write", "K\015\012");
        check("write_we_count", we_count, 1);

        cmd("R3C\015");
        wait_done("readback");
        check_log("readback", "A5\015\012");

        cmd("w2bc7\015R2B\015");
        wait_done("lower_wr_rd");
        check_log("lower_wr_rd", "K\015\012C7\015\012");

        // Malformed commands.
        cmd("W3G\015");
        wait_done("err_hex");
        check_log("err_hex", "?\015\012");
        check("err_busy_after", int'(busy), 0);
        cmd("Q\015R12X\015");
        wait_done("err_misc");
        check_log("err_misc", "?\015\012?\015\012");
        check("err_we_count", we_count, 2);

        // Back-to-back commands queued while the previous one is answered.
        cmd("R10\015W11FF\015R11\015");
        wait_done("b2b");
        check_log("b2b", "4A\015\012K\015\012FF\015\012");

        // TX FIFO full throughout execution, then released.
        tx_full = 1'b1;
        cmd("R10\015");
        repeat (30) @(negedge clk);
        check("full_no_push", tx_log.size(), 0);
        check("full_busy", int'(busy), 1);
        tx_full = 1'b0;
        wait_done("full");
        check_log("full", "4A\015\012");

        // Inter-byte timeout abandons a partial command silently.
        we0 = we_count;
        send("W1");
        repeat (40) @(negedge clk);
        check("timeout_not_yet", int'(busy), 1);
        repeat (20) @(negedge clk);
        check("timeout_abort", int'(busy), 0);
        check("timeout_no_tx", tx_log.size(), 0);
        cmd("R10\015");
        wait_done("after_timeout");
        check_log("after_timeout", "4A\015\012");
        check("timeout_no_we", we_count, we0);

        // Reset in the middle of a response.
        cmd("R3C\015");
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!tx_en && k < 200);
        check("midresp_push_seen", int'(tx_en), 1);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("midresp_tx_en", int'(tx_en), 0);
        check("midresp_busy", int'(busy), 0);
        check("midresp_reg_addr", int'(reg_addr), 0);
        check("midresp_tx_data", int'(tx_data), 0);
        exp_tx.delete();
        tx_log.delete();
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midresp_no_more_tx", tx_log.size(), 0);
        check("midresp_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_host.md
# uart_cmd_host

Host-side command engine attached to the byte interface of the UART FIFO block. It pops ASCII command bytes from the RX FIFO and parses hex read/write commands. It executes each command on a simple register bus and pushes an ASCII response into the TX FIFO. Together with the UART FIFO block it forms a complete serial register-access bridge.

## Interface
- TIMEOUT_CYCLES, default 100_000_000: inter-byte abort timeout inside a partial command, in clk cycles; 0 disables the timeout.
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- rx_empty  input  1  RX FIFO empty; rx_data valid whenever 0 (show-ahead)
- rx_data  input  8  RX FIFO head byte
- rx_en  output  1  RX FIFO pop, one byte per asserted cycle
- tx_full  input  1  TX FIFO full
- tx_en  output  1  TX FIFO push of tx_data
- tx_data  output  8  response byte
- reg_addr  output  8  register bus address
- reg_wdata  output  8  register bus write data
- reg_we  output  1  single-cycle register write strobe
- reg_rdata  input  8  register read data, combinational from reg_addr
- busy  output  1  high in any state except IDLE

## Operation
- Command grammar (hex digits 0-9, A-F and a-f; command letters case-insensitive):
  - Read: 'R' A1 A0 CR. Response: D1 D0 CR LF, with uppercase hex.
  - Write: 'W' A1 A0 D1 D0 CR. Response: 'K' CR LF.
  - Error response: '?' CR LF.
- In IDLE, LF (0x0A) and CR (0x0D) are consumed silently, so CRLF terminals are supported. Any other byte that is not R or W moves the block to ERR.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EOL, ERR, EXEC, RESP.
  - IDLE -> ADDR_HI on 'R' or 'W'; the command type is latched.
  - ADDR_HI -> ADDR_LO -> (read) EOL or (write) DATA_HI -> DATA_LO -> EOL. Each step consumes one hex digit, high nibble first.
  - EOL -> EXEC on CR.
  - Any non-hex byte where a hex digit is expected, or any non-CR byte in EOL -> ERR.
  - ERR consumes bytes until CR, then queues the error response -> RESP.
  - EXEC lasts one cycle.
    - Write: reg_we=1 with the parsed reg_addr and reg_wdata.
    - Read: reg_addr is driven and reg_rdata is captured at the clock edge.
    - Then -> RESP.
  - RESP pushes the response bytes in order, then -> IDLE.
- rx_en = (state in IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EOL, ERR) and !rx_empty. The byte is consumed at the same edge. rx_en is never asserted in EXEC or RESP.
- tx_en = (state==RESP) and !tx_full. The byte index advances only on a push; tx_full stalls without losing bytes. tx_en is never high while tx_full=1.
- tx_data is the current response byte in RESP and 0x00 otherwise.
- reg_addr and reg_wdata are registered. They hold the last parsed values until the next command overwrites them.
- Timeout:
  - In ADDR_HI..EOL, a counter counts cycles with no byte popped and resets on each pop.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE silently, with no response and no register access.
  - The timeout is not active in IDLE, ERR, EXEC or RESP.

## Timing
- Reset (reset=0 at a rising edge) values: state IDLE, rx_en=0, tx_en=0, tx_data=0x00, reg_we=0, reg_addr=0x00, reg_wdata=0x00, busy=0, timeout counter 0.
- Reset mid-command or mid-response aborts immediately. Partial responses are not completed.
- Parsing throughput is one byte per cycle when rx_empty stays 0.
- Latency: terminating CR popped at edge N -> EXEC during cycle N+1 -> first tx_en in cycle N+2 if tx_full=0.
- Response length is 4 pushes for a read and 3 for a write or an error.
- reg_we is high for exactly one cycle per valid write and never for reads, errors or timeouts.
- A read returns reg_rdata sampled in EXEC; later bus changes do not affect the response.
- Bytes arriving during EXEC or RESP remain in the RX FIFO and are parsed after returning to IDLE.

## Test plan
- RX FIFO holds "W3CA5\r" -> reg_we pulses once with reg_addr=0x3C and reg_wdata=0xA5. TX sees 'K',0x0D,0x0A. First tx_en is exactly 2 cycles after the CR pop.
- Register model returns 0x7E at address 0x3C. RX "r3c\r\n" -> TX sees '7','E',0x0D,0x0A; the trailing LF is silently consumed. No reg_we.
- RX "W3G\r" -> TX sees '?',0x0D,0x0A. No reg_we. busy=0 afterwards.
- RX "R10\r" with tx_full held high for 20 cycles after EXEC -> no tx_en while full, then exactly 4 pushes "10-data",CR,LF with none lost or duplicated.
- TIMEOUT_CYCLES=50, RX "W1" then idle for 60 cycles, then "R10\r" -> no output for the aborted command; the read is answered normally.
- reset=0 asserted during RESP after 1 byte pushed -> next cycle tx_en=0, busy=0, reg_addr=0x00; no further response bytes.
